// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
// Optional feature macro: FPGA_CFG_CHECKSUM_EN adds the CHECK state.
package fpga_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_COUNT,
    ST_LOAD,
    ST_WRITE,
`ifdef FPGA_CFG_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [3:0] CFG_SYNC0 = 4'hA;
  localparam logic [3:0] CFG_SYNC1 = 4'h5;

  function automatic int nib_per_frame(input int frame_w);
    return frame_w / 4;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_pin_sync.sv
// Two-flop synchroniser for the configuration pin bundle
// {cfg_en, cfg_strb, cfg_data[3:0]} plus rising-edge detect on the strobe.
module cfg_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pin_in,
  output logic       en_s,
  output logic [3:0] data_s,
  output logic       nib_v
);

  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;
  logic       strb_prev_q, strb_prev_d;

  // each pin advances one stage along its chain every clock
  always_comb begin
    meta_d      = pin_in;
    sync_d      = meta_q;
    strb_prev_d = sync_q[4];
  end

  // synchroniser flops, cleared so stale pin history is dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      strb_prev_q <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      strb_prev_q <= strb_prev_d;
    end
  end

  assign en_s   = sync_q[5];
  assign data_s = sync_q[3:0];
  assign nib_v  = sync_q[4] & ~strb_prev_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Nibble-serial configuration loader: hunts for sync A,5, reads a frame
// count, assembles frames MS nibble first and issues one write per frame.
// Optional feature macro: FPGA_CFG_CHECKSUM_EN (trailing XOR checksum nibble).
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W    = 16,
  parameter int NUM_FRAMES = 8,
  parameter int ADDR_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic               cfg_strb,
  input  logic [3:0]         cfg_data,
  output logic [ADDR_W-1:0]  frame_addr,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_we,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam int NPF   = nib_per_frame(FRAME_W);
  localparam int CNT_W = $clog2(NPF + 1);

  logic       en_s;
  logic [3:0] data_s;
  logic       nib_v;

  cfg_pin_sync u_pin_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_in ({cfg_en, cfg_strb, cfg_data}),
    .en_s   (en_s),
    .data_s (data_s),
    .nib_v  (nib_v)
  );

  cfg_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  frame_addr_q, frame_addr_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic [3:0]         count_q, count_d;
  logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
  logic               pend_q, pend_d;
  logic [3:0]         pend_nib_q, pend_nib_d;
`ifdef FPGA_CFG_CHECKSUM_EN
  logic [3:0]         xor_q, xor_d;
`endif

  logic       nib_avail;
  logic [3:0] nib;
  logic       last_frame;

  assign nib_avail  = nib_v | pend_q;
  assign nib        = pend_q ? pend_nib_q : data_s;
  assign last_frame = (int'(frame_addr_q) == (int'(count_q) - 1));

  // next-state, frame assembly and checksum accumulation
  always_comb begin
    state_d      = state_q;
    frame_addr_d = frame_addr_q;
    frame_data_d = frame_data_q;
    count_d      = count_q;
    nib_cnt_d    = nib_cnt_q;
    pend_d       = 1'b0;
    pend_nib_d   = pend_nib_q;
`ifdef FPGA_CFG_CHECKSUM_EN
    xor_d        = xor_q;
`endif

    if (state_q == ST_WRITE && nib_v) begin
      pend_d     = 1'b1;
      pend_nib_d = data_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (en_s) state_d = ST_SYNC0;
      end
      ST_SYNC0: begin
`ifdef FPGA_CFG_CHECKSUM_EN
        xor_d = '0;
`endif
        if (nib_avail && nib == CFG_SYNC0) state_d = ST_SYNC1;
      end
      ST_SYNC1: begin
`ifdef FPGA_CFG_CHECKSUM_EN
        xor_d = '0;
`endif
        if (nib_avail) begin
          if (nib == CFG_SYNC1)      state_d = ST_COUNT;
          else if (nib != CFG_SYNC0) state_d = ST_SYNC0;
        end
      end
      ST_COUNT: begin
        if (nib_avail) begin
          if (nib == 4'd0 || int'(nib) > NUM_FRAMES) begin
            state_d = ST_ERR;
          end else begin
            count_d      = nib;
            frame_addr_d = '0;
            nib_cnt_d    = '0;
`ifdef FPGA_CFG_CHECKSUM_EN
            xor_d        = xor_q ^ nib;
`endif
            state_d      = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (nib_avail) begin
          frame_data_d = {frame_data_q[FRAME_W-5:0], nib};
`ifdef FPGA_CFG_CHECKSUM_EN
          xor_d        = xor_q ^ nib;
`endif
          if (nib_cnt_q == CNT_W'(NPF - 1)) begin
            nib_cnt_d = '0;
            state_d   = ST_WRITE;
          end else begin
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (last_frame) begin
`ifdef FPGA_CFG_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          frame_addr_d = frame_addr_q + ADDR_W'(1);
          state_d      = ST_LOAD;
        end
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (nib_avail) state_d = (nib == xor_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    if (!en_s && state_q != ST_DONE) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_addr_q <= '0;
      frame_data_q <= '0;
      count_q      <= '0;
      nib_cnt_q    <= '0;
      pend_q       <= 1'b0;
      pend_nib_q   <= '0;
`ifdef FPGA_CFG_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
      count_q      <= count_d;
      nib_cnt_q    <= nib_cnt_d;
      pend_q       <= pend_d;
      pend_nib_q   <= pend_nib_d;
`ifdef FPGA_CFG_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign frame_addr = frame_addr_q;
  assign frame_data = frame_data_q;
  assign frame_we   = (state_q == ST_WRITE);
  assign cfg_done   = (state_q == ST_DONE);
  assign cfg_err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard testbench for fpga_cfg_loader (FRAME_W=16, NUM_FRAMES=8, ADDR_W=3).
// Checksum nibbles and the bad-checksum case are included only when
// FPGA_CFG_CHECKSUM_EN is defined.
module tb_fpga_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        cfg_strb;
  logic [3:0]  cfg_data;
  logic [2:0]  frame_addr;
  logic [15:0] frame_data;
  logic        frame_we;
  logic        cfg_done;
  logic        cfg_err;

  fpga_cfg_loader #(.FRAME_W(16), .NUM_FRAMES(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_strb   (cfg_strb),
    .cfg_data   (cfg_data),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .frame_we   (frame_we),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        expQ[$];
  logic [3:0] stimQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // one nibble: data first, then a strobe pulse; fast mode is 3 clks per nibble
  task automatic applyStimulus(input logic [3:0] nib, input bit fast);
    @(negedge clk) cfg_data = nib;
    @(negedge clk) cfg_strb = 1'b1;
    if (!fast) @(negedge clk);
    @(negedge clk) cfg_strb = 1'b0;
  endtask

  task automatic applyStream(input bit fast);
    while (stimQ.size() > 0) applyStimulus(stimQ.pop_front(), fast);
  endtask

  task automatic resetDut();
    @(negedge clk) rst = 1'b1;
    cfg_en = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic enableLoad();
    @(negedge clk) cfg_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_we"},   32'(frame_we),   32'h0);
    checkOutput({tag, "_done"}, 32'(cfg_done),   32'h0);
    checkOutput({tag, "_err"},  32'(cfg_err),    32'h0);
    checkOutput({tag, "_addr"}, 32'(frame_addr), 32'h0);
    checkOutput({tag, "_data"}, 32'(frame_data), 32'h0);
  endtask

  task automatic checkFinal(input string tag, input logic done, input logic err);
    repeat (8) @(negedge clk);
    checkOutput({tag, "_done"},    32'(cfg_done),    32'(done));
    checkOutput({tag, "_err"},     32'(cfg_err),     32'(err));
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'h0);
  endtask

  // monitor: every frame write is compared against the oldest expected write
  always @(negedge clk) begin
    wr_t expWr;
    if (!rst && frame_we) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 frame_addr, frame_data);
      end else begin
        expWr = expQ.pop_front();
        if (frame_addr !== expWr.addr || frame_data !== expWr.data) begin
          errors++;
          $display("[TB] FAIL frame_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   frame_addr, frame_data, expWr.addr, expWr.data);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] badCounts[2];
    badCounts[0] = 4'h0;
    badCounts[1] = 4'h9;
    rst = 1'b1; cfg_en = 1'b0; cfg_strb = 1'b0; cfg_data = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkZeroOutputs("reset");

    // nominal two-frame load
    $display("[TB] nominal load");
    enableLoad();
    stimQ = '{4'hA, 4'h5, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`ifdef FPGA_CFG_CHECKSUM_EN
    stimQ.push_back(4'hA);
`endif
    expQ.push_back('{addr: 3'd0, data: 16'h1234});
    expQ.push_back('{addr: 3'd1, data: 16'h5678});
    applyStream(1'b0);
    checkFinal("nominal", 1'b1, 1'b0);
    @(negedge clk) cfg_en = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("done_sticky", 32'(cfg_done), 32'h1);

`ifdef FPGA_CFG_CHECKSUM_EN
    // corrupted checksum: frames still written, then error until cfg_en drops
    $display("[TB] bad checksum");
    resetDut();
    enableLoad();
    stimQ = '{4'hA, 4'h5, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB};
    expQ.push_back('{addr: 3'd0, data: 16'h1234});
    expQ.push_back('{addr: 3'd1, data: 16'h5678});
    applyStream(1'b0);
    checkFinal("badsum", 1'b0, 1'b1);
    @(negedge clk) cfg_en = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("badsum_err_clear", 32'(cfg_err), 32'h0);
`endif

    // leading garbage and a repeated sync0 nibble before the real header
    $display("[TB] hunt and resync");
    resetDut();
    enableLoad();
    stimQ = '{4'h3, 4'hA, 4'hA, 4'h5, 4'h1, 4'hD, 4'hE, 4'hA, 4'hD};
`ifdef FPGA_CFG_CHECKSUM_EN
    stimQ.push_back(4'h5);
`endif
    expQ.push_back('{addr: 3'd0, data: 16'hDEAD});
    applyStream(1'b0);
    checkFinal("hunt", 1'b1, 1'b0);

    // frame counts of zero and above NUM_FRAMES are rejected
    foreach (badCounts[i]) begin
      $display("[TB] illegal count %0d", badCounts[i]);
      resetDut();
      enableLoad();
      stimQ = '{4'hA, 4'h5, badCounts[i]};
      applyStream(1'b0);
      checkFinal("badcount", 1'b0, 1'b1);
      @(negedge clk) cfg_en = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("badcount_err_clear", 32'(cfg_err), 32'h0);
    end

    // abort part-way through frame 0, then a clean reload
    $display("[TB] abort and reload");
    resetDut();
    enableLoad();
    stimQ = '{4'hA, 4'h5, 4'h1, 4'h1, 4'h2};
    applyStream(1'b0);
    @(negedge clk) cfg_en = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_done", 32'(cfg_done), 32'h0);
    checkOutput("abort_err",  32'(cfg_err),  32'h0);
    enableLoad();
    stimQ = '{4'hA, 4'h5, 4'h1, 4'hC, 4'hA, 4'hF, 4'hE};
`ifdef FPGA_CFG_CHECKSUM_EN
    stimQ.push_back(4'h6);
`endif
    expQ.push_back('{addr: 3'd0, data: 16'hCAFE});
    applyStream(1'b0);
    checkFinal("reload", 1'b1, 1'b0);

    // reset in the middle of LOAD, then a fast back-to-back stream
    $display("[TB] reset mid-load and fast strobes");
    resetDut();
    enableLoad();
    stimQ = '{4'hA, 4'h5, 4'h2, 4'h1, 4'h2};
    applyStream(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkZeroOutputs("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    stimQ = '{4'hA, 4'h5, 4'h2, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2};
`ifdef FPGA_CFG_CHECKSUM_EN
    stimQ.push_back(4'h2);
`endif
    expQ.push_back('{addr: 3'd0, data: 16'h9876});
    expQ.push_back('{addr: 3'd1, data: 16'h5432});
    applyStream(1'b1);
    checkFinal("fast", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
